// File: rtl/rgb_fade_pwm.sv
// rgb_fade_pwm: three-channel PWM that crossfades an RGB LED through
// red -> green -> blue -> red, using linear fades and hold periods.
// pwm_r/pwm_g/pwm_b feed RGB2PWM/RGB1PWM/RGB0PWM of the SB_RGBA_DRV.
// Optional macro RGB_FADE_GAMMA_EN: when defined, active duties are squared
// (square-law gamma) as they load at each PWM period boundary.
module rgb_fade_pwm #(
   parameter int PWM_BITS    = 8,
   parameter int STEP_CYCLES = 23438,
   parameter int HOLD_STEPS  = 256
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b,
   output logic [2:0] phase,
   output logic       period_tick
);

   localparam int PW = $clog2(STEP_CYCLES + 1);
   localparam int SW = $clog2(HOLD_STEPS + 1);
   localparam logic [PWM_BITS:0] FULL       = {1'b1, {PWM_BITS{1'b0}}};
   localparam logic [PWM_BITS:0] FULL_M1    = FULL - 1'b1;
   localparam logic [PW-1:0]     PRESC_LAST = PW'(STEP_CYCLES - 1);
   localparam logic [SW-1:0]     HOLD_LAST  = SW'(HOLD_STEPS - 1);

   typedef enum logic [2:0] {
      HOLD_R  = 3'd0,
      FADE_RG = 3'd1,
      HOLD_G  = 3'd2,
      FADE_GB = 3'd3,
      HOLD_B  = 3'd4,
      FADE_BR = 3'd5
   } state_t;

   state_t              state, state_next;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PW-1:0]       presc;
   logic [SW-1:0]       step_cnt;
   logic [PWM_BITS:0]   dr, dg, db;   // shadow duties, stepped by the FSM
   logic [PWM_BITS:0]   ar, ag, ab;   // active duties, compared to pwm_cnt
   logic                step, boundary, hold_done, illegal, in_hold;

`ifdef RGB_FADE_GAMMA_EN
   // Square-law shaping: (d*d) >> PWM_BITS, exact at 0 and full scale.
   function automatic logic [PWM_BITS:0] shape(input logic [PWM_BITS:0] d);
      logic [2*PWM_BITS+1:0] sq;
      sq = {{(PWM_BITS+1){1'b0}}, d} * {{(PWM_BITS+1){1'b0}}, d};
      return sq[2*PWM_BITS:PWM_BITS];
   endfunction
`else
   // Linear: the active duty is the shadow duty unchanged.
   function automatic logic [PWM_BITS:0] shape(input logic [PWM_BITS:0] d);
      return d;
   endfunction
`endif

   assign boundary  = enable && (pwm_cnt == '1);
   assign step      = enable && (presc == PRESC_LAST);
   assign hold_done = (step_cnt == HOLD_LAST);
   assign illegal   = state[2] && state[1];
   assign in_hold   = (state == HOLD_R) || (state == HOLD_G) || (state == HOLD_B);

   // PWM period counter, frozen while disabled.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!reset)      pwm_cnt <= '0;
      else if (enable) pwm_cnt <= pwm_cnt + 1'b1;
   end

   // Step prescaler: a step pulse on the terminal count, then back to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      presc <= '0;
      else if (enable) presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= HOLD_R;
      else        state <= state_next;
   end

   // FSM next state: holds advance after HOLD_STEPS steps, fades end when the
   // incoming colour reaches full scale; illegal codes fall back to HOLD_R.
   always_comb begin
      // NOTE: default first so no path leaves state_next unassigned (no latch).
      state_next = state;
      case (state)
         HOLD_R:  if (step && hold_done)      state_next = FADE_RG;
         FADE_RG: if (step && dg == FULL_M1)  state_next = HOLD_G;
         HOLD_G:  if (step && hold_done)      state_next = FADE_GB;
         FADE_GB: if (step && db == FULL_M1)  state_next = HOLD_B;
         HOLD_B:  if (step && hold_done)      state_next = FADE_BR;
         FADE_BR: if (step && dr == FULL_M1)  state_next = HOLD_R;
         default:                             state_next = HOLD_R;
      endcase
   end

   // FSM outputs.
   always_comb begin
      phase       = state;
      period_tick = boundary;
   end

   // Hold step counter, cleared when a hold ends.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                step_cnt <= '0;
      else if (illegal)          step_cnt <= '0;
      else if (step && in_hold)  step_cnt <= hold_done ? '0 : step_cnt + 1'b1;
   end

   // Shadow duties: one count moves from the outgoing to the incoming colour
   // per fade step, keeping their sum at full scale.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset || illegal) begin
         dr <= FULL;
         dg <= '0;
         db <= '0;
      end else if (step) begin
         case (state)
            FADE_RG: begin dr <= dr - 1'b1; dg <= dg + 1'b1; end
            FADE_GB: begin dg <= dg - 1'b1; db <= db + 1'b1; end
            FADE_BR: begin db <= db - 1'b1; dr <= dr + 1'b1; end
            default: ;
         endcase
      end
   end

   // Active duties load only at period boundaries for glitch-free updates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ar <= '0;
         ag <= '0;
         ab <= '0;
      end else if (boundary) begin
         ar <= shape(dr);
         ag <= shape(dg);
         ab <= shape(db);
      end
   end

   // Registered PWM compare, forced low while disabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_r <= 1'b0;
         pwm_g <= 1'b0;
         pwm_b <= 1'b0;
      end else begin
         pwm_r <= enable && ({1'b0, pwm_cnt} < ar);
         pwm_g <= enable && ({1'b0, pwm_cnt} < ag);
         pwm_b <= enable && ({1'b0, pwm_cnt} < ab);
      end
   end

endmodule
